// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl
// Shared line-fill sequencer for an I-cache / D-cache pair. One miss is
// served at a time (D-cache wins a tie). It requests every word of the
// missing line from memory on back-to-back cycles, streams the returned
// words into the owning cache's data array, and writes the tag together
// with the last word. A one-cycle DONE state then lets the tag lookup
// settle before another miss is accepted.
//
// Ports
//   clk               : clock, all state changes on the rising edge
//   rst_n             : synchronous active-low reset
//   miss_detected[1:0]: miss request, bit 0 = I-cache, bit 1 = D-cache
//   miss_address_i/d  : missing byte address per channel
//   memory_data_valid : one returned word this cycle (returns in order)
//   fsm_busy[1:0]     : per-channel stall
//   write_data_array  : per-channel data-array write enable
//   write_tag_array   : per-channel tag-array write enable
//   fill_word_idx     : word index inside the line for the current write
//   memory_address    : memory read address
//   memory_enable     : memory read strobe, one word per asserted cycle
module cache_fill_ctrl #(
    parameter int ADDR_W         = 16,
    parameter int WORDS_PER_LINE = 8,
    parameter int BYTES_PER_WORD = 2,
    localparam int OFF_W = $clog2(WORDS_PER_LINE * BYTES_PER_WORD),
    localparam int IDX_W = $clog2(WORDS_PER_LINE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        miss_detected,
    input  logic [ADDR_W-1:0] miss_address_i,
    input  logic [ADDR_W-1:0] miss_address_d,
    input  logic              memory_data_valid,
    output logic [1:0]        fsm_busy,
    output logic [1:0]        write_data_array,
    output logic [1:0]        write_tag_array,
    output logic [IDX_W-1:0]  fill_word_idx,
    output logic [ADDR_W-1:0] memory_address,
    output logic              memory_enable
);

    localparam int CNT_W   = IDX_W + 1;
    localparam int STEP_SH = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] BASE_MASK = ~(ADDR_W'((1 << OFF_W) - 1));

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_r;
    logic              sel_r;
    logic [ADDR_W-1:0] base_r;
    logic [CNT_W-1:0]  issue_cnt_r;
    logic [CNT_W-1:0]  recv_cnt_r;

    logic              issuing_s;
    logic              accept_s;
    logic              last_recv_s;
    logic              last_issue_s;
    logic [ADDR_W-1:0] word_addr_s;

    // One-hot channel mask for the served channel.
    function automatic logic [1:0] chan_mask(input logic ch);
        chan_mask = ch ? 2'b10 : 2'b01;
    endfunction

    // Per-cycle fill events: word issue, word acceptance and end-of-line.
    always_comb begin
        issuing_s    = (state_r == ST_REQ);
        accept_s     = memory_data_valid &&
                       ((state_r == ST_REQ) || (state_r == ST_WAIT));
        last_recv_s  = accept_s && (recv_cnt_r == LAST_WORD);
        last_issue_s = issuing_s && (issue_cnt_r == LAST_WORD);
        // Word step is a power of two, so the multiply is a shift; the add
        // wraps naturally at the top of the address space.
        word_addr_s  = base_r + (ADDR_W'(issue_cnt_r) << STEP_SH);
    end

    // Output decode. Everything is qualified by rst_n so a reset cycle
    // never issues or writes, even before the state register has cleared.
    always_comb begin
        fsm_busy         = miss_detected;
        write_data_array = 2'b00;
        write_tag_array  = 2'b00;
        fill_word_idx    = {IDX_W{1'b0}};
        memory_address   = {ADDR_W{1'b0}};
        memory_enable    = 1'b0;
        if (rst_n) begin
            if (state_r != ST_IDLE) begin
                fsm_busy = miss_detected | chan_mask(sel_r);
            end else begin
                fsm_busy = miss_detected;
            end
            if (issuing_s) begin
                memory_enable  = 1'b1;
                memory_address = word_addr_s;
            end else begin
                memory_enable  = 1'b0;
                memory_address = {ADDR_W{1'b0}};
            end
            if (accept_s) begin
                write_data_array = chan_mask(sel_r);
                fill_word_idx    = recv_cnt_r[IDX_W-1:0];
            end else begin
                write_data_array = 2'b00;
                fill_word_idx    = {IDX_W{1'b0}};
            end
            if (last_recv_s) begin
                write_tag_array = chan_mask(sel_r);
            end else begin
                write_tag_array = 2'b00;
            end
        end else begin
            fsm_busy = miss_detected;
        end
    end

    // Fill sequencer: latches the served miss, counts issued and returned
    // words independently (they may coincide), and finishes on the last return.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            sel_r       <= 1'b0;
            base_r      <= {ADDR_W{1'b0}};
            issue_cnt_r <= {CNT_W{1'b0}};
            recv_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|miss_detected) begin
                        sel_r       <= miss_detected[1];
                        base_r      <= (miss_detected[1] ? miss_address_d
                                                         : miss_address_i) & BASE_MASK;
                        issue_cnt_r <= {CNT_W{1'b0}};
                        recv_cnt_r  <= {CNT_W{1'b0}};
                        state_r     <= ST_REQ;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    issue_cnt_r <= issue_cnt_r + CNT_ONE;
                    if (accept_s) begin
                        recv_cnt_r <= recv_cnt_r + CNT_ONE;
                    end
                    // A zero-latency memory can finish the line while still
                    // issuing, which skips WAIT entirely.
                    if (last_recv_s) begin
                        state_r <= ST_DONE;
                    end else if (last_issue_s) begin
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (accept_s) begin
                        recv_cnt_r <= recv_cnt_r + CNT_ONE;
                    end
                    if (last_recv_s) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cache_fill_ctrl.md
CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16, address width in bits.
REQ-002 Parameter WORDS_PER_LINE, default 8, words per cache line; power of two, 2..64.
REQ-003 Parameter BYTES_PER_WORD, default 2, byte-address step between consecutive words; power of two.
REQ-004 Derived: OFF_W = log2(WORDS_PER_LINE*BYTES_PER_WORD); IDX_W = log2(WORDS_PER_LINE).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 miss_detected  input  2  per-channel miss request; bit 0 = I-cache, bit 1 = D-cache.
REQ-008 miss_address_i  input  ADDR_W  I-cache missing address.
REQ-009 miss_address_d  input  ADDR_W  D-cache missing address.
REQ-010 memory_data_valid  input  1  memory returned one word this cycle; words return in request order.
REQ-011 fsm_busy  output  2  per-channel stall.
REQ-012 write_data_array  output  2  per-channel data-array write enable.
REQ-013 write_tag_array  output  2  per-channel tag-array write enable.
REQ-014 fill_word_idx  output  IDX_W  word index within line for current data write.
REQ-015 memory_address  output  ADDR_W  memory read address.
REQ-016 memory_enable  output  1  memory read request strobe; one word per asserted cycle.

Function
REQ-017 States: IDLE, REQ, WAIT, DONE; encoding free.
REQ-018 IDLE: if any miss_detected bit set, latch served channel sel (D-cache wins when both set), latch base = selected miss address with low OFF_W bits cleared, clear issue_cnt and recv_cnt, go REQ next cycle.
REQ-019 REQ: memory_enable=1, memory_address = base + issue_cnt*BYTES_PER_WORD; issue_cnt increments each cycle; after issuing word WORDS_PER_LINE-1, go WAIT.
REQ-020 WAIT: memory_enable=0, memory_address=0; wait for remaining returns.
REQ-021 In REQ or WAIT, each memory_data_valid: write_data_array[sel]=1, fill_word_idx=recv_cnt, recv_cnt increments.
REQ-022 Valid with recv_cnt==WORDS_PER_LINE-1: write_data_array[sel]=1 and write_tag_array[sel]=1 same cycle; go DONE, from REQ or WAIT.
REQ-023 DONE: lasts exactly one cycle, no outputs except fsm_busy; go IDLE; lets the tag lookup settle so a stale miss does not restart a fill.
REQ-024 Valid in the same cycle as an issue is legal; both counters update.
REQ-025 memory_data_valid in IDLE or DONE is ignored: no writes, no counter change.
REQ-026 fsm_busy[c] = miss_detected[c] OR (state != IDLE AND sel == c).
REQ-027 Miss deassertion mid-fill does not abort; the fill completes.
REQ-028 Address changes on miss_address_i/d after latching have no effect on the current fill.
REQ-029 Address addition wraps modulo 2^ADDR_W; issue_cnt and recv_cnt are IDX_W+1 bits wide, with no overflow beyond WORDS_PER_LINE.
REQ-030 Pending non-selected channel is served on the first IDLE cycle after DONE.
REQ-031 Outputs other than fsm_busy are zero whenever state is IDLE or DONE, except as stated.

Reset
REQ-032 rst_n=0 at a clock edge: state IDLE, sel=0, base=0, issue_cnt=recv_cnt=0.
REQ-033 During and after reset: write_data_array=0, write_tag_array=0, memory_enable=0, memory_address=0, fill_word_idx=0.
REQ-034 During and after reset, fsm_busy equals miss_detected (combinational term only).
REQ-035 Reset mid-fill abandons the fill with no tag write; late memory_data_valid after reset is ignored.

Verification
REQ-036 I-miss 0x1237, defaults, valid 4 cycles after each enable:
- Addresses 0x1230,0x1232,...,0x123E issued on 8 consecutive cycles.
- 8 data writes with fill_word_idx 0..7.
- write_tag_array=2'b01 on the 8th write.
- DONE, then IDLE.
REQ-037 Both misses same cycle (I 0x0040, D 0x8010):
- D filled first from 0x8010.
- fsm_busy=2'b11 throughout.
- I fill starts the cycle after D's DONE, from 0x0040.
REQ-038 Valid on same cycle as first request (zero latency):
- recv_cnt tracks issue_cnt.
- Tag write on the last REQ cycle.
- Direct REQ->DONE transition.
REQ-039 rst_n low after 3 words returned:
- All outputs zero next cycle.
- Further valid pulses produce no writes.
- New miss restarts at word 0.
REQ-040 WORDS_PER_LINE=4, BYTES_PER_WORD=4, ADDR_W=16, miss 0xFFFB:
- Base 0xFFF0; addresses 0xFFF0,0xFFF4,0xFFF8,0xFFFC.
- Tag write after the 4th valid.
REQ-041 Stray memory_data_valid pulses in IDLE and DONE: no data or tag writes.
